// File: rtl/arbitro_sumador.sv
// arbitro_sumador: one registered WIDTH-bit adder shared by two requesters
// (port 0 = fetch PC+4, port 1 = branch target PC+offset).
// Grants one request per free slot, latches its operands, adds them and holds
// the tagged result until the consumer accepts it.
// Optional build macro ARB_PRIO_FIJA_EN: fixed priority (requester 0 wins ties)
// instead of the default round-robin.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   LIBRE   | adder free; a pending request is granted (ack) this cycle
//   CALC    | operands latched; sum is registered at the next edge
//   ENTREGA | O/O_id/O_valid held until O_ready is seen
module arbitro_sumador #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  output logic             O_id,
  input  logic             O_ready
);

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    CALC    = 2'd1,
    ENTREGA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             o_id_q, o_id_d;
  logic             last_id_q, last_id_d;
  logic             gnt0, gnt1;

  // Pick the winner among the currently asserted requests
  always_comb begin
`ifdef ARB_PRIO_FIJA_EN
    gnt0 = req0;
`else
    // On a tie, the requester that was not served last goes first
    gnt0 = req0 && (!req1 || last_id_q);
`endif
    gnt1 = req1 && !gnt0;
  end

  // Next-state, datapath next values and ack strobes
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    o_id_d    = o_id_q;
    last_id_d = last_id_q;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state_q)
      LIBRE: begin
        if (!rst && (gnt0 || gnt1)) begin
          ack0      = gnt0;
          ack1      = gnt1;
          opa_d     = gnt0 ? a0 : a1;
          opb_d     = gnt0 ? b0 : b1;
          o_id_d    = gnt1;
          last_id_d = gnt1;
          state_d   = CALC;
        end
      end
      CALC: begin
        o_d       = opa_q + opb_q;
        o_valid_d = 1'b1;
        state_d   = ENTREGA;
      end
      ENTREGA: begin
        if (O_ready) begin
          o_valid_d = 1'b0;
          state_d   = LIBRE;
        end
      end
      default: state_d = LIBRE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight sum
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LIBRE;
      opa_q     <= '0;
      opb_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_id_q    <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_id_q    <= o_id_d;
      last_id_q <= last_id_d;
    end
  end

  assign O       = o_q;
  assign O_valid = o_valid_q;
  assign O_id    = o_id_q;

endmodule
